gcd_engine: RTL and testbench

GCD_ENGINE -- requirements
Module: gcd_engine

---
 rtl/gcd_engine.sv | 115 +++++++++++
 tb/tb_gcd_engine.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/gcd_engine.sv
`default_nettype none
// ============================================================================
// Module      : gcd_engine
// Description : Subtractive (Euclid) GCD engine with IDLE/CALC/DONE control.
//               Optional iteration counter enabled by macro GCD_ITER_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module gcd_engine #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] gcd_out,
    output logic             err
`ifdef GCD_ITER_COUNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;

    logic w_accept;
    logic w_zero_op;

    assign w_accept  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_zero_op = (a_in == '0) || (b_in == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            gcd_out <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        r_a <= a_in;
                        r_b <= b_in;
                        // A zero operand needs no iteration: the other one is the result.
                        if (w_zero_op) begin
                            r_state <= S_DONE;
                            gcd_out <= a_in | b_in;
                            err     <= (a_in == '0) && (b_in == '0);
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_state <= S_CALC;
                            err     <= 1'b0;
                            busy    <= 1'b1;
                            done    <= 1'b0;
                        end
                    end else if (r_state == S_DONE) begin
                        r_state <= S_IDLE;
                        done    <= 1'b0;
                    end
                end
                S_CALC: begin
                    // Larger operand is always the minuend, so no underflow.
                    if (r_a > r_b) begin
                        r_a <= r_a - r_b;
                    end else if (r_b > r_a) begin
                        r_b <= r_b - r_a;
                    end else begin
                        gcd_out <= r_a;
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

`ifdef GCD_ITER_COUNT_EN
    localparam logic [WIDTH-1:0] c_CNT_MAX = {WIDTH{1'b1}};

    logic w_sub;
    assign w_sub = (r_state == S_CALC) && (r_a != r_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_cnt <= '0;
        end else if (w_accept) begin
            iter_cnt <= '0;
        end else if (w_sub && (iter_cnt != c_CNT_MAX)) begin
            iter_cnt <= iter_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_gcd_engine
// Description : Directed self-checking bench for gcd_engine (WIDTH=16).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_gcd_engine;

    localparam int c_WIDTH = 16;
    localparam int c_LIMIT = 70000;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [c_WIDTH-1:0] a_in;
    logic [c_WIDTH-1:0] b_in;
    logic               busy;
    logic               done;
    logic [c_WIDTH-1:0] gcd_out;
    logic               err;
`ifdef GCD_ITER_COUNT_EN
    logic [c_WIDTH-1:0] iter_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    gcd_engine #(.WIDTH(c_WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .gcd_out (gcd_out),
        .err     (err)
`ifdef GCD_ITER_COUNT_EN
        ,
        .iter_cnt(iter_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; issues one start pulse and follows the run to done.
    task automatic run_op(input string tag, input logic [c_WIDTH-1:0] a, input logic [c_WIDTH-1:0] b,
                          input int exp_gcd, input int exp_err, input int exp_edges,
                          input int exp_busy, input int exp_iter);
        int edges;
        int busy_cycles;
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        tick();
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        edges       = 1;
        busy_cycles = 0;
        while (!done && edges < c_LIMIT) begin
            if (busy) busy_cycles++;
            tick();
            edges++;
        end
        check({tag, " done"},    {31'd0, done}, 32'd1);
        check({tag, " latency"}, edges, exp_edges);
        check({tag, " busy"},    busy_cycles, exp_busy);
        check({tag, " gcd"},     {16'd0, gcd_out}, exp_gcd);
        check({tag, " err"},     {31'd0, err}, exp_err);
`ifdef GCD_ITER_COUNT_EN
        check({tag, " iter"},    {16'd0, iter_cnt}, exp_iter);
`else
        if (exp_iter < 0) $display("note: negative iter expectation");
`endif
        tick();
        check({tag, " done pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        #1;
        check("rst busy", {31'd0, busy}, 32'd0);
        check("rst done", {31'd0, done}, 32'd0);
        check("rst gcd",  {16'd0, gcd_out}, 32'd0);
        check("rst err",  {31'd0, err}, 32'd0);
        #12;
        rst_n = 1'b1;
        tick();
        check("idle hold gcd", {16'd0, gcd_out}, 32'd0);

        run_op("48_18", 16'd48, 16'd18, 6, 0, 6, 5, 4);
        run_op("12_12", 16'd12, 16'd12, 12, 0, 2, 1, 0);
        run_op("0_35",  16'd0,  16'd35, 35, 0, 1, 0, 0);
        run_op("0_0",   16'd0,  16'd0,  0, 1, 1, 0, 0);
        tick();
        check("err hold", {31'd0, err}, 32'd1);

        // 100,75 with a held second start that is ignored in CALC and taken in DONE
        begin
            int edges;
            start = 1'b1;
            a_in  = 16'd100;
            b_in  = 16'd75;
            tick();
            check("100_75 err clr", {31'd0, err}, 32'd0);
            a_in  = 16'd9;
            b_in  = 16'd3;
            edges = 1;
            while (!done && edges < c_LIMIT) begin
                tick();
                edges++;
            end
            check("100_75 latency", edges, 5);
            check("100_75 gcd", {16'd0, gcd_out}, 32'd25);
            tick();
            start = 1'b0;
            check("b2b busy", {31'd0, busy}, 32'd1);
            check("b2b done low", {31'd0, done}, 32'd0);
            edges = 1;
            while (!done && edges < c_LIMIT) begin
                tick();
                edges++;
            end
            check("9_3 latency", edges, 4);
            check("9_3 gcd", {16'd0, gcd_out}, 32'd3);
            tick();
        end

        run_op("65535_1", 16'hFFFF, 16'd1, 1, 0, 65536, 65535, 65534);

        // Reset mid-CALC must clear outputs immediately and suppress done
        begin
            int done_seen;
            start = 1'b1;
            a_in  = 16'hFFFF;
            b_in  = 16'd1;
            tick();
            start = 1'b0;
            repeat (100) tick();
            check("mid busy", {31'd0, busy}, 32'd1);
            #2;
            rst_n = 1'b0;
            #1;
            check("async busy", {31'd0, busy}, 32'd0);
            check("async gcd",  {16'd0, gcd_out}, 32'd0);
            check("async done", {31'd0, done}, 32'd0);
            #3;
            rst_n = 1'b1;
            done_seen = 0;
            repeat (100) begin
                tick();
                if (done || busy) done_seen++;
            end
            check("no done after abort", done_seen, 0);
        end

        run_op("21_14", 16'd21, 16'd14, 7, 0, 4, 3, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
